// File: rtl/sp_ram_loader.sv
// Streams words into a single-port RAM from address 0 upward, then reads the range back
// and flags a mismatch between the write and read checksums.
module sp_ram_loader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned   SUM_W  = DATA_W + ADDR_W;
    localparam logic [ADDR_W:0] Depth  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StFlush,
        StVerify,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [ADDR_W:0]   rcnt_q, rcnt_d;
    logic [SUM_W-1:0]  wsum_q, wsum_d;
    logic [SUM_W-1:0]  rsum_q, rsum_d;
    logic              rd_pend_q, rd_pend_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   len_clamped;

    assign len_clamped = (len > Depth) ? Depth : len;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        wsum_d      = wsum_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = err_q;
        // Read data arrives one cycle after a read enable is on the bus.
        rd_pend_d   = mem_en_q && !mem_we_q;
        rsum_d      = rsum_q + (rd_pend_q ? {{ADDR_W{1'b0}}, mem_rdata} : '0);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_d     = len_clamped;
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                    wsum_d  = '0;
                    rsum_d  = '0;
                    err_d   = 1'b0;
                    state_d = (len_clamped == '0) ? StDone : StWrite;
                end
            end
            StWrite: begin
                if (in_valid) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wcnt_q[ADDR_W-1:0];
                    mem_wdata_d = in_data;
                    wcnt_d      = wcnt_q + CntOne;
                    wsum_d      = wsum_q + {{ADDR_W{1'b0}}, in_data};
                    if (wcnt_q == n_q - CntOne) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                rcnt_d  = '0;
                state_d = StVerify;
            end
            StVerify: begin
                mem_en_d   = 1'b1;
                mem_addr_d = rcnt_q[ADDR_W-1:0];
                rcnt_d     = rcnt_q + CntOne;
                if (rcnt_q == n_q - CntOne) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                // rsum_d already includes the final read word.
                done_d  = 1'b1;
                err_d   = (rsum_d != wsum_q);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            n_q         <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wsum_q      <= '0;
            rsum_q      <= '0;
            rd_pend_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wsum_q      <= wsum_d;
            rsum_q      <= rsum_d;
            rd_pend_q   <= rd_pend_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == StWrite);
    assign busy      = (state_q != StIdle);
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sp_ram_loader.sv
// Directed bench for sp_ram_loader with a behavioural 1-cycle-read RAM and bus monitor.
module tb_sp_ram_loader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          done;
    logic          err;

    sp_ram_loader #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // RAM model; corrupt makes the readback of address 1 return 0x21.
    logic [DW-1:0] ram [16];
    bit corrupt = 1'b0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= (corrupt && mem_addr == 4'd1) ? 8'h21 : ram[mem_addr];
        end
    end

    logic [DW-1:0] stim [20];
    int wr_n, rd_n, wr_bad, rd_bad;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                if (wr_n >= 20 || mem_addr != wr_n[3:0] || mem_wdata != stim[wr_n]) wr_bad++;
                wr_n++;
            end else begin
                if (mem_addr != rd_n[3:0]) rd_bad++;
                rd_n++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int done_n, done_edge, start_edge, acc_n;

    // Starts a load at the next edge and streams stim[] for a fixed cycle budget.
    task automatic run_load(input logic [AW:0] l, input bit stall, input int budget);
        int idx;
        bit acc;
        idx = 0;
        wr_n = 0; rd_n = 0; wr_bad = 0; rd_bad = 0;
        done_n = 0; done_edge = 0;
        len = l;
        start = 1'b1;
        start_edge = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < budget; t++) begin
            in_valid = stall ? (t % 2 == 1) : 1'b1;
            in_data = stim[(idx < 20) ? idx : 19];
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            if (done) begin
                done_n++;
                done_edge = edge_cnt;
            end
        end
        in_valid = 1'b0;
        acc_n = idx;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        bit acc;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full depth, continuous stream
        for (int i = 0; i < 20; i++) stim[i] = 8'(i);
        run_load(5'd16, 1'b0, 50);
        check_eq("t1_writes", 32'(wr_n), 32'd16);
        check_eq("t1_wr_bad", 32'(wr_bad), 32'd0);
        check_eq("t1_reads", 32'(rd_n), 32'd16);
        check_eq("t1_rd_bad", 32'(rd_bad), 32'd0);
        check_eq("t1_done_n", 32'(done_n), 32'd1);
        check_eq("t1_done_lat", 32'(done_edge - start_edge), 32'd35);
        check_eq("t1_err", 32'(err), 32'd0);

        // 2: stalled stream
        stim[0] = 8'hA5; stim[1] = 8'h5A; stim[2] = 8'hFF; stim[3] = 8'h01;
        run_load(5'd4, 1'b1, 30);
        check_eq("t2_writes", 32'(wr_n), 32'd4);
        check_eq("t2_wr_bad", 32'(wr_bad), 32'd0);
        check_eq("t2_reads", 32'(rd_n), 32'd4);
        check_eq("t2_done_n", 32'(done_n), 32'd1);
        check_eq("t2_err", 32'(err), 32'd0);
        check_eq("t2_busy", 32'(busy), 32'd0);

        // 3: corrupted readback
        stim[0] = 8'h10; stim[1] = 8'h20; stim[2] = 8'h30;
        corrupt = 1'b1;
        run_load(5'd3, 1'b0, 20);
        corrupt = 1'b0;
        check_eq("t3_done_n", 32'(done_n), 32'd1);
        check_eq("t3_done_lat", 32'(done_edge - start_edge), 32'd9);
        check_eq("t3_err_held", 32'(err), 32'd1);

        // 4: zero length clears err and touches no RAM
        run_load(5'd0, 1'b0, 10);
        check_eq("t4_mem_access", 32'(wr_n + rd_n), 32'd0);
        check_eq("t4_done_n", 32'(done_n), 32'd1);
        check_eq("t4_done_lat", 32'(done_edge - start_edge), 32'd1);
        check_eq("t4_err", 32'(err), 32'd0);

        // 5: restart ignored while busy, reset after 5 accepts
        for (int i = 0; i < 20; i++) stim[i] = 8'h40 + 8'(i);
        wr_n = 0; rd_n = 0; wr_bad = 0; rd_bad = 0;
        len = 5'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc_n = 0;
        for (int t = 0; t < 20 && acc_n < 5; t++) begin
            start = (t == 2);
            if (t == 2) len = 5'd2;
            in_valid = 1'b1;
            in_data = stim[acc_n];
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) acc_n++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        check_eq("t5_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t5_rst");
        check_eq("t5_accepts", 32'(acc_n), 32'd5);
        check_eq("t5_writes", 32'(wr_n), 32'd4);
        check_eq("t5_wr_bad", 32'(wr_bad), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stim[0] = 8'h77; stim[1] = 8'h88;
        run_load(5'd2, 1'b0, 20);
        check_eq("t5b_writes", 32'(wr_n), 32'd2);
        check_eq("t5b_wr_bad", 32'(wr_bad), 32'd0);
        check_eq("t5b_reads", 32'(rd_n), 32'd2);
        check_eq("t5b_done_n", 32'(done_n), 32'd1);
        check_eq("t5b_done_lat", 32'(done_edge - start_edge), 32'd7);
        check_eq("t5b_err", 32'(err), 32'd0);

        // 6: over-length request clamps to depth
        for (int i = 0; i < 20; i++) stim[i] = 8'hC0 + 8'(i);
        run_load(5'd20, 1'b0, 60);
        check_eq("t6_writes", 32'(wr_n), 32'd16);
        check_eq("t6_wr_bad", 32'(wr_bad), 32'd0);
        check_eq("t6_reads", 32'(rd_n), 32'd16);
        check_eq("t6_rd_bad", 32'(rd_bad), 32'd0);
        check_eq("t6_accepts", 32'(acc_n), 32'd16);
        check_eq("t6_done_n", 32'(done_n), 32'd1);
        check_eq("t6_done_lat", 32'(done_edge - start_edge), 32'd35);
        check_eq("t6_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
